alu_core: RTL and testbench

// - Registered 32-bit integer ALU for the 5-stage CPU datapath; receives the decoded R-type operands (rs, rt),

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/alu_shifter.sv | 20 ++
 rtl/alu_core.sv | 82 ++++++++
 tb/tb_alu_core.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, R-type funct codes and the shifter mode type.
package cpu_pkg;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_SRA  = 6'b000011;
    localparam logic [5:0] FUNCT_MFHI = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO = 6'b010010;
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU = 6'b101011;

    typedef enum logic [1:0] {
        SHIFT_LL = 2'd0,
        SHIFT_RL = 2'd1,
        SHIFT_RA = 2'd2
    } shift_mode_t;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for sll/srl/sra; only ever shifts operand B.
module alu_shifter
    import cpu_pkg::*;
(
    input  logic [WIDTH-1:0]   dataIn,
    input  logic [SHAMT_W-1:0] shamt,
    input  shift_mode_t        mode,
    output logic [WIDTH-1:0]   dataOut
);

    always_comb begin
        dataOut = dataIn << shamt;
        case (mode)
            SHIFT_RL: dataOut = dataIn >> shamt;
            SHIFT_RA: dataOut = $unsigned($signed(dataIn) >>> shamt);
            default:  dataOut = dataIn << shamt;
        endcase
    end

endmodule

// File: rtl/alu_core.sv
// Registered 32-bit ALU: operands captured on one edge, result registered on the next,
// so the value lines up with the CPU write-back stage two clocks after presentation.
module alu_core
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    input  logic [5:0]           Signal,
    input  logic [SHAMT_W-1:0]   shamt,
    input  logic [2*WIDTH-1:0]   hilo,
    output logic [WIDTH-1:0]     dataOut
);

    logic [WIDTH-1:0]   aReg;
    logic [WIDTH-1:0]   bReg;
    logic [5:0]         signalReg;
    logic [SHAMT_W-1:0] shamtReg;
    logic [2*WIDTH-1:0] hiloReg;
    logic [WIDTH-1:0]   shiftResult;
    logic [WIDTH-1:0]   result;
    shift_mode_t        shiftMode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aReg      <= '0;
            bReg      <= '0;
            signalReg <= '0;
            shamtReg  <= '0;
            hiloReg   <= '0;
        end else begin
            aReg      <= dataA;
            bReg      <= dataB;
            signalReg <= Signal;
            shamtReg  <= shamt;
            hiloReg   <= hilo;
        end
    end

    always_comb begin
        shiftMode = SHIFT_LL;
        if (signalReg == FUNCT_SRL)
            shiftMode = SHIFT_RL;
        else if (signalReg == FUNCT_SRA)
            shiftMode = SHIFT_RA;
    end

    alu_shifter shifter (
        .dataIn  (bReg),
        .shamt   (shamtReg),
        .mode    (shiftMode),
        .dataOut (shiftResult)
    );

    // Overflow on add/sub is deliberately ignored; unknown funct codes produce zero.
    always_comb begin
        result = '0;
        case (signalReg)
            FUNCT_ADD, FUNCT_ADDU:           result = aReg + bReg;
            FUNCT_SUB, FUNCT_SUBU:           result = aReg - bReg;
            FUNCT_AND:                       result = aReg & bReg;
            FUNCT_OR:                        result = aReg | bReg;
            FUNCT_XOR:                       result = aReg ^ bReg;
            FUNCT_NOR:                       result = ~(aReg | bReg);
            FUNCT_SLT:                       result = {{(WIDTH-1){1'b0}}, ($signed(aReg) < $signed(bReg))};
            FUNCT_SLTU:                      result = {{(WIDTH-1){1'b0}}, (aReg < bReg)};
            FUNCT_SLL, FUNCT_SRL, FUNCT_SRA: result = shiftResult;
            FUNCT_MFHI:                      result = hiloReg[2*WIDTH-1:WIDTH];
            FUNCT_MFLO:                      result = hiloReg[WIDTH-1:0];
            default:                         result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dataOut <= '0;
        else
            dataOut <= result;
    end

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed cases plus random ops against a reference model.
module tb_alu_core;
    import cpu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic [4:0]  shamt;
    logic [63:0] hilo;
    logic [31:0] dataOut;

    int          checks = 0;
    int          errors = 0;
    string       pendTag;
    logic [31:0] pendExp;

    logic [5:0]  codes [16] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011,
                                6'b100100, 6'b100101, 6'b100110, 6'b100111,
                                6'b101010, 6'b101011, 6'b000000, 6'b000010,
                                6'b000011, 6'b010000, 6'b010010, 6'b111111};

    alu_core dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .dataA   (dataA),
        .dataB   (dataB),
        .Signal  (Signal),
        .shamt   (shamt),
        .hilo    (hilo),
        .dataOut (dataOut)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural reference: plain arithmetic, arithmetic shift built from a logical shift plus sign fill.
    function automatic logic [31:0] refModel(input logic [31:0] a, input logic [31:0] b,
                                             input logic [5:0] sig, input logic [4:0] sh,
                                             input logic [63:0] hl);
        logic [31:0] fill;
        fill = b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
        case (sig)
            6'b100000, 6'b100001: return a + b;
            6'b100010, 6'b100011: return a - b;
            6'b100100: return a & b;
            6'b100101: return a | b;
            6'b100110: return a ^ b;
            6'b100111: return ~(a | b);
            6'b101010: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            6'b101011: return (a < b) ? 32'd1 : 32'd0;
            6'b000000: return b << sh;
            6'b000010: return b >> sh;
            6'b000011: return (b >> sh) | fill;
            6'b010000: return hl[63:32];
            6'b010010: return hl[31:0];
            default:   return 32'd0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] expected);
        checks++;
        assert (dataOut === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, dataOut, expected);
        end
    endtask

    // Each call presents one op; the edge that captures it shows the previous op's result.
    task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                                 input logic [5:0] sig, input logic [4:0] sh,
                                 input logic [63:0] hl, input logic [31:0] expected);
        @(negedge clk);
        dataA  = a;
        dataB  = b;
        Signal = sig;
        shamt  = sh;
        hilo   = hl;
        @(posedge clk);
        #1;
        checkOutput(pendTag, pendExp);
        pendTag = tag;
        pendExp = expected;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [5:0]  rs;
        logic [4:0]  rsh;
        logic [63:0] rhl;

        rst_n  = 1'b0;
        dataA  = '0;
        dataB  = '0;
        Signal = '0;
        shamt  = '0;
        hilo   = '0;
        pendTag = "post_reset";
        pendExp = 32'd0;
        #12;
        checkOutput("reset", 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("add_0_1",   32'd0, 32'd1, FUNCT_ADD, 5'd0, 64'd0, 32'd1);
        applyStimulus("add_4_5",   32'd4, 32'd5, FUNCT_ADD, 5'd0, 64'd0, 32'd9);
        applyStimulus("sub_9_8",   32'd9, 32'd8, FUNCT_SUB, 5'd0, 64'd0, 32'd1);
        applyStimulus("sub_0_1",   32'd0, 32'd1, FUNCT_SUB, 5'd0, 64'd0, 32'hFFFF_FFFF);
        applyStimulus("add_wrap",  32'hFFFF_FFFF, 32'd1, FUNCT_ADD, 5'd0, 64'd0, 32'd0);
        applyStimulus("srl_11_2",  32'hDEAD_BEEF, 32'd11, FUNCT_SRL, 5'd2, 64'd0, 32'd2);
        applyStimulus("sra_neg",   32'd0, 32'h8000_0000, FUNCT_SRA, 5'd4, 64'd0, 32'hF800_0000);
        applyStimulus("sll_31",    32'd7, 32'd1, FUNCT_SLL, 5'd31, 64'd0, 32'h8000_0000);
        applyStimulus("mfhi",      32'd3, 32'd9, FUNCT_MFHI, 5'd0, 64'hFFFF_FFFF_0000_0007, 32'hFFFF_FFFF);
        applyStimulus("mflo",      32'd3, 32'd9, FUNCT_MFLO, 5'd0, 64'hFFFF_FFFF_0000_0007, 32'd7);
        applyStimulus("slt_m1_1",  32'hFFFF_FFFF, 32'd1, FUNCT_SLT, 5'd0, 64'd0, 32'd1);
        applyStimulus("sltu_m1_1", 32'hFFFF_FFFF, 32'd1, FUNCT_SLTU, 5'd0, 64'd0, 32'd0);
        applyStimulus("undef_3f",  32'h1234_5678, 32'h0F0F_0F0F, 6'b111111, 5'd3, 64'd5, 32'd0);
        applyStimulus("nop_pass",  32'hAAAA_AAAA, 32'h0000_1234, FUNCT_SLL, 5'd0, 64'd0, 32'h0000_1234);
        applyStimulus("nor",       32'hF0F0_0000, 32'h0000_0F0F, FUNCT_NOR, 5'd0, 64'd0, 32'h0F0F_F0F0);

        for (int i = 0; i < 40; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rs  = codes[$urandom_range(0, 15)];
            rsh = 5'($urandom_range(0, 31));
            rhl = {$urandom, $urandom};
            applyStimulus("random", ra, rb, rs, rsh, rhl, refModel(ra, rb, rs, rsh, rhl));
        end

        // Mid-stream async reset: output must clear before any clock edge.
        @(negedge clk);
        dataA  = '0;
        dataB  = '0;
        Signal = '0;
        shamt  = '0;
        hilo   = '0;
        rst_n  = 1'b0;
        #1;
        checkOutput("async_reset", 32'd0);
        @(posedge clk);
        #1;
        checkOutput("reset_hold", 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        pendTag = "post_release";
        pendExp = 32'd0;

        applyStimulus("add_after_rst", 32'd100, 32'd23, FUNCT_ADD, 5'd0, 64'd0, 32'd123);
        applyStimulus("xor_after_rst", 32'hFF00_FF00, 32'h0FF0_0FF0, FUNCT_XOR, 5'd0, 64'd0, 32'hF0F0_F0F0);
        for (int i = 0; i < 20; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rs  = codes[$urandom_range(0, 15)];
            rsh = 5'($urandom_range(0, 31));
            rhl = {$urandom, $urandom};
            applyStimulus("random2", ra, rb, rs, rsh, rhl, refModel(ra, rb, rs, rsh, rhl));
        end
        applyStimulus("flush", 32'd0, 32'd0, 6'b111111, 5'd0, 64'd0, 32'd0);
        applyStimulus("flush2", 32'd0, 32'd0, 6'b111111, 5'd0, 64'd0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
